// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam int ADDR_W_DEF     = 10;
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // A new load may only begin from a state where no load is in progress.
  function automatic logic can_start(state_t s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
//
// Stream handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready depends only on loader state, never on
// in_valid; the source may hold in_valid low for any number of cycles.
// imem_we is a single-cycle strobe; imem_addr/imem_wdata hold between strobes.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Host side: drives the stream, observes memory writes.
  modport master (
    output in_byte, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_byte, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words; flags the 4th byte of each word.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;
  logic [23:0]      sr;   // first three bytes of the word, byte0 lowest

  assign word_valid = byte_valid && (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign word       = {byte_in, sr};

  // Shift bytes in from the top so byte0 ends in bits [7:0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      sr  <= '0;
    end else if (clr) begin
      idx <= '0;
      sr  <= '0;
    end else if (byte_valid) begin
      idx <= idx + 1'b1;
      sr  <= {byte_in, sr[23:8]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed program image, writes it to
// instruction memory, verifies an XOR checksum and then releases the core.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded,
  output state_t            dbg_state
);

  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

  state_t          state;
  logic            len_phase;   // 0: expecting LEN_LO, 1: expecting LEN_HI
  logic [7:0]      len_lo;
  logic [15:0]     n_words;
  logic [ADDR_W:0] word_idx;
  logic [7:0]      csum;

  logic        accept;
  logic        pk_clr;
  logic        pk_valid;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len_n;
  logic        last_word;

  assign accept    = bus.in_valid && bus.in_ready;
  assign pk_clr    = start && can_start(state);
  assign pk_valid  = accept && (state == ST_DATA);
  assign len_n     = {bus.in_byte, len_lo};
  assign last_word = (16'(word_idx) + 16'd1) == n_words;
  assign dbg_state = state;

  prog_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_in    (bus.in_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // Loader FSM with word counter, running checksum and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      len_phase      <= 1'b0;
      len_lo         <= '0;
      n_words        <= '0;
      word_idx       <= '0;
      csum           <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_run        <= 1'b0;
      load_err       <= 1'b0;
      words_loaded   <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      // Count a word once its write strobe has been presented.
      if (bus.imem_we) words_loaded <= words_loaded + 1'b1;

      if (word_valid) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= word_idx[ADDR_W-1:0];
        bus.imem_wdata <= word;
        word_idx       <= word_idx + 1'b1;
      end
      if (pk_valid) csum <= csum ^ bus.in_byte;

      case (state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (start) begin
            state        <= ST_LEN;
            bus.in_ready <= 1'b1;
            cpu_run      <= 1'b0;
            load_err     <= 1'b0;
            len_phase    <= 1'b0;
            word_idx     <= '0;
            csum         <= '0;
            words_loaded <= '0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            if (!len_phase) begin
              len_lo    <= bus.in_byte;
              len_phase <= 1'b1;
            end else begin
              n_words <= len_n;
              if ({1'b0, len_n} > CAPACITY) begin
                state        <= ST_ERROR;
                bus.in_ready <= 1'b0;
                load_err     <= 1'b1;
              end else if (len_n == 16'd0) begin
                state <= ST_CSUM;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (word_valid && last_word) state <= ST_CSUM;
        end
        ST_CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (bus.in_byte == csum) begin
              state   <= ST_RUN;
              cpu_run <= 1'b1;
            end else begin
              state    <= ST_ERROR;
              load_err <= 1'b1;
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
